// File: rtl/addsub_pkg.sv
// Shared op codes, FSM encodings and datapath width for the sliced add/sub controller.
package addsub_pkg;
  localparam int DATA_W = 32;

  typedef enum logic [1:0] {
    OP_ADD  = 2'b00,
    OP_SUB  = 2'b01,
    OP_SLT  = 2'b10,
    OP_SLTU = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_e;
endpackage

// File: rtl/addsub_slice.sv
// Combinational slice: conditionally invert b, then ripple-add with cin.
// Also exposes the carry into the slice MSB so the top slice can supply c31.
module addsub_slice #(
  parameter int SLICE_W = 8
) (
  input  logic [SLICE_W-1:0] a,
  input  logic [SLICE_W-1:0] b,
  input  logic               inv,
  input  logic               cin,
  output logic [SLICE_W-1:0] sum,
  output logic               cout,
  output logic               cmsb
);
  logic [SLICE_W-1:0] bx;
  logic [SLICE_W:0]   c;

  always_comb begin
    bx   = b ^ {SLICE_W{inv}};
    sum  = '0;
    c    = '0;
    c[0] = cin;
    for (int i = 0; i < SLICE_W; i++) begin
      sum[i]   = a[i] ^ bx[i] ^ c[i];
      c[i+1]   = (a[i] & bx[i]) | (c[i] & (a[i] ^ bx[i]));
    end
  end

  assign cout = c[SLICE_W];
  assign cmsb = c[SLICE_W-1];
endmodule

// File: rtl/addsub_seq_ctrl.sv
// Sequenced ADD/SUB/SLT/SLTU, SLICE_W bits per cycle; response valid NSLICE cycles after accept.
// Holds result/flags in DONE until resp_ready; no new request is taken until then.
module addsub_seq_ctrl
  import addsub_pkg::*;
#(
  parameter int SLICE_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        req_op,
  input  logic [DATA_W-1:0] req_a,
  input  logic [DATA_W-1:0] req_b,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] result,
  output logic              zero,
  output logic              carry,
  output logic              overflow
);
  localparam int NSLICE = DATA_W / SLICE_W;
  localparam int IDX_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;

  state_e              state;
  op_e                 op_q;
  logic [DATA_W-1:0]   a_q, b_q;
  logic                inv_q, cin_q;
  logic [IDX_W-1:0]    slice_idx;

  logic [5:0]          base;
  logic [SLICE_W-1:0]  sum_s;
  logic                cout_s, cmsb_s, ovf_s, last;
  logic [DATA_W-1:0]   full_sum, final_res;
  logic                carry_f, ovf_f;

  assign base = 6'(slice_idx) * 6'(SLICE_W);
  assign last = (slice_idx == IDX_W'(NSLICE - 1));

  addsub_slice #(.SLICE_W(SLICE_W)) u_slice (
    .a    (a_q[base +: SLICE_W]),
    .b    (b_q[base +: SLICE_W]),
    .inv  (inv_q),
    .cin  (cin_q),
    .sum  (sum_s),
    .cout (cout_s),
    .cmsb (cmsb_s)
  );

  // On the last slice cmsb/cout are c31/c32 of the full 32-bit add.
  always_comb begin
    full_sum                  = result;
    full_sum[base +: SLICE_W] = sum_s;
    ovf_s                     = cmsb_s ^ cout_s;
    final_res                 = full_sum;
    carry_f                   = 1'b0;
    ovf_f                     = 1'b0;
    case (op_q)
      OP_ADD, OP_SUB: begin
        carry_f = cout_s;
        ovf_f   = ovf_s;
      end
      OP_SLT:  final_res = {{(DATA_W-1){1'b0}}, full_sum[DATA_W-1] ^ ovf_s};
      OP_SLTU: final_res = {{(DATA_W-1){1'b0}}, ~cout_s};
      default: final_res = full_sum;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      result     <= '0;
      zero       <= 1'b0;
      carry      <= 1'b0;
      overflow   <= 1'b0;
      slice_idx  <= '0;
      cin_q      <= 1'b0;
      inv_q      <= 1'b0;
      op_q       <= OP_ADD;
      a_q        <= '0;
      b_q        <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_valid && req_ready) begin
            a_q       <= req_a;
            b_q       <= req_b;
            op_q      <= op_e'(req_op);
            inv_q     <= (req_op != OP_ADD);
            cin_q     <= (req_op != OP_ADD);
            slice_idx <= '0;
            req_ready <= 1'b0;
            state     <= ST_CALC;
          end
        end
        ST_CALC: begin
          cin_q <= cout_s;
          if (last) begin
            result     <= final_res;
            zero       <= (final_res == '0);
            carry      <= carry_f;
            overflow   <= ovf_f;
            slice_idx  <= '0;
            resp_valid <= 1'b1;
            state      <= ST_DONE;
          end else begin
            result    <= full_sum;
            slice_idx <= slice_idx + 1'b1;
          end
        end
        ST_DONE: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            req_ready  <= 1'b1;
            state      <= ST_IDLE;
          end
        end
        default: begin
          state      <= ST_IDLE;
          req_ready  <= 1'b1;
          resp_valid <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_addsub_seq_ctrl.sv
// Scoreboard bench: instance 0 (SLICE_W=8) runs directed cases, instances 1..3 (SLICE_W 1/4/32) random sweeps.
module tb_addsub_seq_ctrl;
  typedef struct packed {
    logic [31:0] res;
    logic        z;
    logic        c;
    logic        v;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid [4];
  logic        req_ready [4];
  logic [1:0]  req_op    [4];
  logic [31:0] req_a     [4];
  logic [31:0] req_b     [4];
  logic        resp_valid[4];
  logic        resp_ready[4];
  logic [31:0] result    [4];
  logic        zero      [4];
  logic        carry     [4];
  logic        overflow  [4];

  exp_t sb_q[4][$];
  int   n_chk  = 0;
  int   n_pass = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    localparam int SW = (g == 0) ? 8 : (g == 1) ? 1 : (g == 2) ? 4 : 32;
    addsub_seq_ctrl #(.SLICE_W(SW)) u_dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req_valid  (req_valid[g]),
      .req_ready  (req_ready[g]),
      .req_op     (req_op[g]),
      .req_a      (req_a[g]),
      .req_b      (req_b[g]),
      .resp_valid (resp_valid[g]),
      .resp_ready (resp_ready[g]),
      .result     (result[g]),
      .zero       (zero[g]),
      .carry      (carry[g]),
      .overflow   (overflow[g])
    );
  end

  function automatic int nslice_of(input int k);
    case (k)
      0:       return 4;
      1:       return 32;
      2:       return 8;
      default: return 1;
    endcase
  endfunction

  function automatic exp_t model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    exp_t        e;
    logic [32:0] s;
    e = '0;
    case (op)
      2'd0: begin
        s     = {1'b0, a} + {1'b0, b};
        e.res = s[31:0];
        e.c   = s[32];
        e.v   = (a[31] == b[31]) && (s[31] != a[31]);
      end
      2'd1: begin
        s     = {1'b0, a} + {1'b0, ~b} + 33'd1;
        e.res = s[31:0];
        e.c   = s[32];
        e.v   = (a[31] != b[31]) && (s[31] != a[31]);
      end
      2'd2:    e.res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      default: e.res = (a < b) ? 32'd1 : 32'd0;
    endcase
    e.z = (e.res == 32'd0);
    return e;
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0:       return 32'h0000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic issue(input int k, input logic [1:0] op, input logic [31:0] a,
                       input logic [31:0] b, output int waited);
    req_valid[k] = 1'b1;
    req_op[k]    = op;
    req_a[k]     = a;
    req_b[k]     = b;
    waited       = 0;
    while (!req_ready[k] && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    if (!req_ready[k]) check("accept_timeout", 64'(req_ready[k]), 64'd1);
    sb_q[k].push_back(model(op, a, b));
    @(negedge clk);
    req_valid[k] = 1'b0;
  endtask

  task automatic collect(input int k, input string tag);
    int   lat;
    exp_t e;
    lat = 0;
    while (!resp_valid[k] && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    check({tag, "_lat"}, 64'(lat), 64'(nslice_of(k)));
    if (sb_q[k].size() > 0) begin
      e = sb_q[k].pop_front();
      check({tag, "_res"}, 64'(result[k]),   64'(e.res));
      check({tag, "_z"},   64'(zero[k]),     64'(e.z));
      check({tag, "_c"},   64'(carry[k]),    64'(e.c));
      check({tag, "_v"},   64'(overflow[k]), 64'(e.v));
    end
  endtask

  task automatic consume(input int k);
    resp_ready[k] = 1'b1;
    @(negedge clk);
    resp_ready[k] = 1'b0;
  endtask

  task automatic run_random(input int k, input int n);
    int          w;
    logic [1:0]  op;
    logic [31:0] a, b;
    for (int i = 0; i < n; i++) begin
      op = 2'($urandom_range(0, 3));
      a  = pick();
      b  = pick();
      issue(k, op, a, b, w);
      collect(k, "rnd");
      repeat ($urandom_range(0, 2)) @(negedge clk);
      consume(k);
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not complete, passed %0d of %0d", n_pass, n_chk);
    $fatal(1);
  end

  initial begin
    logic [1:0]  d_op[6] = '{2'd0, 2'd1, 2'd1, 2'd2, 2'd3, 2'd2};
    logic [31:0] d_a [6] = '{32'h0000_00FF, 32'h8000_0000, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h7FFF_FFFF};
    logic [31:0] d_b [6] = '{32'h0000_0001, 32'h0000_0001, 32'd5, 32'h0000_0001, 32'h0000_0001, 32'h8000_0000};
    int          w;
    exp_t        e_bp;

    for (int k = 0; k < 4; k++) begin
      req_valid[k]  = 1'b0;
      req_op[k]     = 2'd0;
      req_a[k]      = '0;
      req_b[k]      = '0;
      resp_ready[k] = 1'b0;
    end
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_req_ready",  64'(req_ready[0]),  64'd1);
    check("rst_resp_valid", 64'(resp_valid[0]), 64'd0);
    check("rst_result",     64'(result[0]),     64'd0);
    check("rst_zero",       64'(zero[0]),       64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 6; i++) begin
      issue(0, d_op[i], d_a[i], d_b[i], w);
      collect(0, $sformatf("dir%0d", i));
      consume(0);
    end

    // Response held off for 10 cycles while a competing request waits.
    e_bp = model(2'd0, 32'h1234_5678, 32'h1111_1111);
    issue(0, 2'd0, 32'h1234_5678, 32'h1111_1111, w);
    collect(0, "bp");
    for (int i = 0; i < 10; i++) begin
      req_valid[0] = 1'b1;
      req_op[0]    = 2'd1;
      req_a[0]     = 32'h0000_DEAD;
      req_b[0]     = 32'h0000_0001;
      @(negedge clk);
      check("bp_hold_res",   64'(result[0]),     64'(e_bp.res));
      check("bp_hold_vld",   64'(resp_valid[0]), 64'd1);
      check("bp_hold_ready", 64'(req_ready[0]),  64'd0);
    end
    check("bp_hold_c", 64'(carry[0]),    64'(e_bp.c));
    check("bp_hold_v", 64'(overflow[0]), 64'(e_bp.v));
    consume(0);
    check("bp_ready_after", 64'(req_ready[0]),  64'd1);
    check("bp_vld_after",   64'(resp_valid[0]), 64'd0);
    issue(0, 2'd1, 32'h0000_DEAD, 32'h0000_0001, w);
    check("bp_accept_wait", 64'(w), 64'd0);
    collect(0, "bp2");
    consume(0);

    // Reset after two slices of an in-flight add discards it.
    issue(0, 2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, w);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("mid_rst_result",   64'(result[0]),     64'd0);
    check("mid_rst_zero",     64'(zero[0]),       64'd0);
    check("mid_rst_carry",    64'(carry[0]),      64'd0);
    check("mid_rst_ovf",      64'(overflow[0]),   64'd0);
    check("mid_rst_ready",    64'(req_ready[0]),  64'd1);
    check("mid_rst_vld",      64'(resp_valid[0]), 64'd0);
    if (sb_q[0].size() > 0) void'(sb_q[0].pop_front());
    rst_n = 1'b1;
    @(negedge clk);
    issue(0, 2'd0, 32'd1, 32'd1, w);
    collect(0, "post_rst");
    consume(0);

    fork
      run_random(1, 1000);
      run_random(2, 1000);
      run_random(3, 1000);
    join

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
